// File: rtl/beamformer_pkg.sv
// Shared definitions for the delay-and-sum beamformer core.
// Holds the FSM state encoding, a constant-foldable clog2 and the
// accumulator width helper.
package beamformer_pkg;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_ACCUM = 2'd1,
      ST_DONE  = 2'd2
   } bf_state_e;

   function automatic int clog2(input int value);
      int r;
      r = 0;
      while ((1 << r) < value) r++;
      return r;
   endfunction

   // Width that holds the sum of n_ch signed data_w samples without overflow.
   function automatic int acc_width(input int data_w, input int n_ch);
      return data_w + clog2(n_ch);
   endfunction

endpackage

// File: rtl/das_beamformer_core_if.sv
// Frame, configuration and status bundle of the beamformer core.
// master: frame source / config host (drives sample_valid, pcm_in, ch_en,
//         cfg_wr, cfg_ch, cfg_delay, ovr_clr; observes results).
// slave : the core (drives sum_out, out_valid, busy, overrun).
interface das_beamformer_core_if
   import beamformer_pkg::*;
#(
   parameter int N_CH   = 8,
   parameter int DATA_W = 19,
   parameter int DEPTH  = 32,
   parameter int OUT_W  = 32
);
   localparam int CH_W  = clog2(N_CH);
   localparam int DLY_W = clog2(DEPTH);

   logic                     sample_valid;
   logic [N_CH*DATA_W-1:0]   pcm_in;
   logic [N_CH-1:0]          ch_en;
   logic                     cfg_wr;
   logic [CH_W-1:0]          cfg_ch;
   logic [DLY_W-1:0]         cfg_delay;
   logic                     ovr_clr;
   logic [OUT_W-1:0]         sum_out;
   logic                     out_valid;
   logic                     busy;
   logic                     overrun;

   modport master (
      output sample_valid, pcm_in, ch_en, cfg_wr, cfg_ch, cfg_delay, ovr_clr,
      input  sum_out, out_valid, busy, overrun
   );

   modport slave (
      input  sample_valid, pcm_in, ch_en, cfg_wr, cfg_ch, cfg_delay, ovr_clr,
      output sum_out, out_valid, busy, overrun
   );

endinterface

// File: rtl/das_beamformer_core_pcm_delay_line.sv
// Single-channel circular sample buffer, DEPTH x DATA_W.
// Ports: clk, rst (sync, active-low, clears every entry), wr_en/wr_addr/
//        wr_data (registered write), rd_addr/rd_data (combinational read).
module pcm_delay_line
   import beamformer_pkg::*;
#(
   parameter int DEPTH  = 32,
   parameter int DATA_W = 19,
   localparam int AW    = clog2(DEPTH)
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              wr_en,
   input  logic [AW-1:0]     wr_addr,
   input  logic [DATA_W-1:0] wr_data,
   input  logic [AW-1:0]     rd_addr,
   output logic [DATA_W-1:0] rd_data
);

   logic [DATA_W-1:0] mem_q [DEPTH];
   logic [DATA_W-1:0] mem_d [DEPTH];

   always_comb begin
      mem_d = mem_q;
      if (wr_en) mem_d[wr_addr] = wr_data;
   end

   // Cleared on reset so that delays reaching before the first frame read 0.
   always_ff @(posedge clk) begin
      if (!rst) begin
         for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
      end else begin
         mem_q <= mem_d;
      end
   end

   assign rd_data = mem_q[rd_addr];

endmodule

// File: rtl/das_beamformer_core.sv
// Delay-and-sum beamformer core. Each accepted frame is written into N_CH
// circular buffers, then each channel is read back at its own delay and
// summed serially, one channel per cycle.
// Ports: clk, rst (sync, active-low), bus (slave side of
//        das_beamformer_core_if: frame input, delay config, results/status).
//
// state | meaning
// IDLE  | waiting for sample_valid; accepts and captures a frame
// ACCUM | adding channel k of the captured frame, k = 0..N_CH-1
// DONE  | sum_out presented with out_valid; frame input still blocked
module das_beamformer_core
   import beamformer_pkg::*;
#(
   parameter int N_CH   = 8,
   parameter int DATA_W = 19,
   parameter int DEPTH  = 32,
   parameter int OUT_W  = 32
) (
   input  logic                 clk,
   input  logic                 rst,
   das_beamformer_core_if.slave bus
);

   localparam int CH_W  = clog2(N_CH);
   localparam int DLY_W = clog2(DEPTH);
   localparam int ACC_W = acc_width(DATA_W, N_CH);

   bf_state_e                state_q, state_d;
   logic [DLY_W-1:0]         wr_ptr_q, wr_ptr_d;
   logic [DLY_W-1:0]         fp_q, fp_d;
   logic [CH_W-1:0]          k_q, k_d;
   logic [DLY_W-1:0]         dly_tab_q [N_CH];
   logic [DLY_W-1:0]         dly_tab_d [N_CH];
   logic [DLY_W-1:0]         dly_shd_q [N_CH];
   logic [DLY_W-1:0]         dly_shd_d [N_CH];
   logic [N_CH-1:0]          en_shd_q, en_shd_d;
   logic signed [ACC_W-1:0]  acc_q, acc_d;
   logic signed [OUT_W-1:0]  sum_q, sum_d;
   logic                     ovr_q, ovr_d;

   logic                     wr_en;
   logic [DLY_W-1:0]         rd_addr [N_CH];
   logic [DATA_W-1:0]        rd_data [N_CH];
   logic signed [ACC_W-1:0]  term;
   logic signed [ACC_W-1:0]  acc_sum;

   // Buffer depth is a power of two, so the subtraction wraps modulo DEPTH.
   always_comb begin
      for (int c = 0; c < N_CH; c++) rd_addr[c] = fp_q - dly_shd_q[c];
   end

   for (genvar g = 0; g < N_CH; g++) begin : g_line
      pcm_delay_line #(
         .DEPTH  (DEPTH),
         .DATA_W (DATA_W)
      ) u_line (
         .clk     (clk),
         .rst     (rst),
         .wr_en   (wr_en),
         .wr_addr (wr_ptr_q),
         .wr_data (bus.pcm_in[g*DATA_W +: DATA_W]),
         .rd_addr (rd_addr[g]),
         .rd_data (rd_data[g])
      );
   end

   always_comb begin
      term = '0;
      if (en_shd_q[k_q]) term = ACC_W'($signed(rd_data[k_q]));
      acc_sum = acc_q + term;
   end

   always_comb begin
      state_d   = state_q;
      wr_ptr_d  = wr_ptr_q;
      fp_d      = fp_q;
      k_d       = k_q;
      dly_tab_d = dly_tab_q;
      dly_shd_d = dly_shd_q;
      en_shd_d  = en_shd_q;
      acc_d     = acc_q;
      sum_d     = sum_q;
      ovr_d     = ovr_q;
      wr_en     = 1'b0;

      // Table update comes first so a same-cycle snapshot sees the new delay.
      if (bus.cfg_wr && (int'(bus.cfg_ch) < N_CH)) dly_tab_d[bus.cfg_ch] = bus.cfg_delay;

      // Clear first; a dropped sample below overrides it (set wins).
      if (bus.ovr_clr) ovr_d = 1'b0;

      case (state_q)
         ST_IDLE: begin
            if (bus.sample_valid) begin
               wr_en     = 1'b1;
               fp_d      = wr_ptr_q;
               wr_ptr_d  = wr_ptr_q + DLY_W'(1);
               dly_shd_d = dly_tab_d;
               en_shd_d  = bus.ch_en;
               acc_d     = '0;
               k_d       = '0;
               state_d   = ST_ACCUM;
            end
         end
         ST_ACCUM: begin
            acc_d = acc_sum;
            k_d   = k_q + CH_W'(1);
            if (k_q == CH_W'(N_CH - 1)) begin
               sum_d   = OUT_W'(acc_sum);
               state_d = ST_DONE;
            end
            if (bus.sample_valid) ovr_d = 1'b1;
         end
         ST_DONE: begin
            state_d = ST_IDLE;
            if (bus.sample_valid) ovr_d = 1'b1;
         end
         default: state_d = ST_IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (!rst) begin
         state_q  <= ST_IDLE;
         wr_ptr_q <= '0;
         fp_q     <= '0;
         k_q      <= '0;
         for (int c = 0; c < N_CH; c++) begin
            dly_tab_q[c] <= '0;
            dly_shd_q[c] <= '0;
         end
         en_shd_q <= '0;
         acc_q    <= '0;
         sum_q    <= '0;
         ovr_q    <= 1'b0;
      end else begin
         state_q   <= state_d;
         wr_ptr_q  <= wr_ptr_d;
         fp_q      <= fp_d;
         k_q       <= k_d;
         dly_tab_q <= dly_tab_d;
         dly_shd_q <= dly_shd_d;
         en_shd_q  <= en_shd_d;
         acc_q     <= acc_d;
         sum_q     <= sum_d;
         ovr_q     <= ovr_d;
      end
   end

   assign bus.sum_out   = sum_q;
   assign bus.out_valid = (state_q == ST_DONE);
   assign bus.busy      = (state_q == ST_ACCUM);
   assign bus.overrun   = ovr_q;

endmodule

// File: tb/tb_das_beamformer_core.sv
// Scoreboard bench for das_beamformer_core. The driver keeps a frame-level
// reference model (history of accepted frames, delay table, frame spacing
// rule) and pushes expected sums with their due cycle; a negedge monitor
// pops and compares whenever out_valid is seen.
module tb_das_beamformer_core;

   localparam int N_CH   = 8;
   localparam int DATA_W = 19;
   localparam int DEPTH  = 32;
   localparam int OUT_W  = 32;

   typedef struct {
      longint sum;
      int     cyc;
   } exp_t;

   logic clk;
   logic rst;
   int   cyc;
   int   checks;
   int   failures;

   exp_t sb[$];
   int   hist[$];
   int   nframes;
   int   m_dly [N_CH];
   bit   m_ovr;
   bit   have_last;
   int   last_e;

   das_beamformer_core_if #(.N_CH(N_CH), .DATA_W(DATA_W), .DEPTH(DEPTH), .OUT_W(OUT_W)) bus ();

   das_beamformer_core #(.N_CH(N_CH), .DATA_W(DATA_W), .DEPTH(DEPTH), .OUT_W(OUT_W)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   task automatic chk(input string name, input longint act, input longint exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   function automatic int rnd_sample();
      return int'($urandom_range(0, (1 << DATA_W) - 1)) - (1 << (DATA_W - 1));
   endfunction

   // Monitor: every out_valid must match the oldest expected frame, on time.
   always @(negedge clk) begin
      if (rst) begin
         if (bus.out_valid) begin
            if (sb.size() == 0) begin
               chk("unexpected_out_valid", 1, 0);
            end else begin
               chk("latency", cyc, sb[0].cyc);
               chk("sum_out", longint'($signed(bus.sum_out)), sb[0].sum);
               void'(sb.pop_front());
            end
         end else if (sb.size() > 0 && cyc > sb[0].cyc) begin
            chk("missing_out_valid", 0, 1);
            void'(sb.pop_front());
         end
      end
   end

   // One clock of stimulus; model is updated, then the edge is awaited and
   // the status flags are checked against the model.
   task automatic cycle(input bit sv, input int smp[N_CH], input logic [N_CH-1:0] en,
                        input bit cw, input int cc, input int cd, input bit oc);
      int     e;
      bit     acc;
      longint s;
      bit     exp_busy;
      e = cyc + 1;
      bus.sample_valid = sv;
      for (int c = 0; c < N_CH; c++) bus.pcm_in[c*DATA_W +: DATA_W] = DATA_W'(smp[c]);
      bus.ch_en     = en;
      bus.cfg_wr    = cw;
      bus.cfg_ch    = 3'(cc);
      bus.cfg_delay = 5'(cd);
      bus.ovr_clr   = oc;
      if (cw && cc < N_CH) m_dly[cc] = cd;
      acc = sv && (!have_last || e >= last_e + N_CH + 2);
      if (acc) begin
         for (int c = 0; c < N_CH; c++) hist.push_back(smp[c]);
         s = 0;
         for (int c = 0; c < N_CH; c++) begin
            if (en[c] && nframes - m_dly[c] >= 0) s += hist[(nframes - m_dly[c]) * N_CH + c];
         end
         nframes++;
         have_last = 1'b1;
         last_e = e;
         sb.push_back('{s, e + N_CH});
      end
      if (sv && !acc) m_ovr = 1'b1;
      else if (oc) m_ovr = 1'b0;
      @(posedge clk);
      #1;
      exp_busy = have_last && cyc >= last_e && cyc <= last_e + N_CH - 1;
      chk("overrun", bus.overrun, m_ovr);
      chk("busy", bus.busy, exp_busy);
   endtask

   task automatic idle(input int n);
      int f[N_CH];
      for (int i = 0; i < n; i++) begin
         foreach (f[c]) f[c] = rnd_sample();
         cycle(0, f, N_CH'($urandom), 0, 0, 0, 0);
      end
   endtask

   task automatic cfg(input int ch, input int d);
      int f[N_CH];
      foreach (f[c]) f[c] = 0;
      cycle(0, f, '1, 1, ch, d, 0);
   endtask

   // Accept a frame, wait for its DONE cycle and compare with a hand value.
   task automatic frame_chk(input string name, input int f[N_CH], input logic [N_CH-1:0] en,
                            input longint exp);
      cycle(1, f, en, 0, 0, 0, 0);
      idle(N_CH);
      chk({name, "_valid"}, bus.out_valid, 1);
      chk(name, longint'($signed(bus.sum_out)), exp);
      idle(1);
   endtask

   task automatic do_reset();
      bus.sample_valid = 1'b0;
      bus.cfg_wr = 1'b0;
      bus.ovr_clr = 1'b0;
      rst = 1'b0;
      @(posedge clk);
      #1;
      sb.delete();
      hist.delete();
      nframes = 0;
      have_last = 1'b0;
      m_ovr = 1'b0;
      foreach (m_dly[c]) m_dly[c] = 0;
      chk("rst_sum_out", bus.sum_out, 0);
      chk("rst_out_valid", bus.out_valid, 0);
      chk("rst_busy", bus.busy, 0);
      chk("rst_overrun", bus.overrun, 0);
      @(posedge clk);
      #1;
      rst = 1'b1;
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1, "watchdog");
   end

   initial begin
      int f[N_CH];
      int g[N_CH];
      checks = 0;
      failures = 0;
      rst = 1'b0;
      bus.sample_valid = 1'b0;
      bus.pcm_in = '0;
      bus.ch_en = '0;
      bus.cfg_wr = 1'b0;
      bus.cfg_ch = '0;
      bus.cfg_delay = '0;
      bus.ovr_clr = 1'b0;
      repeat (2) @(posedge clk);
      #1;
      do_reset();

      // All channels 100, delays 0: latency, busy window, sum 800.
      foreach (f[c]) f[c] = 100;
      cycle(1, f, '1, 0, 0, 0, 0);
      for (int i = 1; i <= N_CH; i++) begin
         chk("busy_window", bus.busy, 1);
         idle(1);
      end
      chk("c9_out_valid", bus.out_valid, 1);
      chk("c9_busy", bus.busy, 0);
      chk("c9_sum", longint'($signed(bus.sum_out)), 800);
      idle(1);

      // ch0 delay 3: zeros until history exists.
      do_reset();
      cfg(0, 3);
      for (int i = 1; i <= 5; i++) begin
         foreach (f[c]) f[c] = 0;
         f[0] = i;
         frame_chk("delay3_sum", f, '1, (i > 3) ? i - 3 : 0);
      end

      // Most negative sample on every channel.
      do_reset();
      foreach (f[c]) f[c] = -(1 << (DATA_W - 1));
      frame_chk("min_sum", f, '1, -2097152);
      chk("min_sum_hex", bus.sum_out, 64'hFFE00000);

      // Single enabled channel; random ch_en while accumulating must not leak.
      do_reset();
      foreach (f[c]) f[c] = c + 1;
      frame_chk("en_mask_sum", f, 8'b0000_0001, 1);
      frame_chk("en_all_sum", f, '1, 36);

      // Overrun: second frame 3 cycles later is dropped.
      foreach (f[c]) f[c] = rnd_sample();
      cycle(1, f, '1, 0, 0, 0, 0);
      idle(2);
      foreach (g[c]) g[c] = rnd_sample();
      cycle(1, g, '1, 0, 0, 0, 0);
      chk("ovr_set", bus.overrun, 1);
      idle(N_CH);
      foreach (g[c]) g[c] = 0;
      cycle(0, g, '1, 0, 0, 0, 1);
      chk("ovr_clr", bus.overrun, 0);
      // Dropped sample together with ovr_clr: set wins.
      cycle(1, f, '1, 0, 0, 0, 0);
      cycle(1, g, '1, 0, 0, 0, 1);
      chk("ovr_set_wins", bus.overrun, 1);
      idle(N_CH + 1);
      cycle(0, g, '1, 0, 0, 0, 1);
      // Pointer advanced once per accepted frame: delay 1 reads previous frame.
      cfg(0, 1);
      foreach (g[c]) g[c] = 5;
      frame_chk("ptr_once", g, 8'b0000_0001, f[0]);
      // Table write in the same cycle as an accepted frame is seen by it.
      foreach (g[c]) g[c] = 7;
      cycle(1, g, 8'b0000_0010, 1, 1, 1, 0);
      idle(N_CH + 1);

      // Wrap-around: ch2 delay 31 over a 40-frame ramp.
      do_reset();
      cfg(2, 31);
      for (int n = 0; n < 40; n++) begin
         foreach (f[c]) f[c] = n + 1;
         frame_chk("wrap_ch2", f, 8'b0000_0100, (n >= 31) ? n - 30 : 0);
      end

      // Random frames, spacing (including overruns), masks and delay writes.
      for (int i = 0; i < 120; i++) begin
         foreach (f[c]) f[c] = rnd_sample();
         if ($urandom_range(0, 3) == 0)
            cycle(0, f, '1, 1, int'($urandom_range(0, N_CH - 1)), int'($urandom_range(0, DEPTH - 1)),
                  $urandom_range(0, 1) == 1);
         cycle(1, f, N_CH'($urandom), $urandom_range(0, 4) == 0,
               int'($urandom_range(0, N_CH - 1)), int'($urandom_range(0, DEPTH - 1)),
               $urandom_range(0, 5) == 0);
         idle(int'($urandom_range(0, 12)));
      end
      idle(N_CH + 2);

      // Reset in the middle of ACCUM: no result for the aborted frame.
      foreach (f[c]) f[c] = 1000;
      cycle(1, f, '1, 0, 0, 0, 0);
      idle(3);
      do_reset();
      for (int i = 0; i < N_CH + 4; i++) begin
         chk("abort_no_valid", bus.out_valid, 0);
         idle(1);
      end
      chk("abort_sum_out", bus.sum_out, 0);
      chk("sb_drained", sb.size(), 0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
